// File: rtl/bcd_serial_adder_if.sv
// Operand/result bundle for the serial packed-BCD adder.
// Latency: none (wires only).
// Backpressure: none; start is a request strobe and busy tells the driver when it will be sampled.
//
// Ports (signals):
//   start      request to add a + b + cin, sampled by the adder only while idle
//   a, b       packed-BCD operands, digit i at [4i+3:4i]
//   cin        carry into digit 0
//   busy       adder is running or presenting its result
//   done       one-cycle pulse when sum/cout/err are final
//   sum        packed-BCD result
//   cout       decimal carry out of the most-significant digit
//   err        some latched operand digit was above 9
// Modports: master drives the request and reads the result, slave is the adder.
interface bcd_serial_adder_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  err;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, err
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, err
    );
endinterface

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder, one digit per clock, least-significant digit first.
// Latency: DIGITS cycles from start acceptance to done; start-to-start spacing DIGITS+2 cycles.
// Backpressure: none; start is only sampled in IDLE and is dropped (not queued) while busy.
//
// Ports:
//   clk   sole clock, rising edge
//   rst   synchronous active-high reset
//   bus   slave side of bcd_serial_adder_if (start/a/b/cin in, busy/done/sum/cout/err out)
// The interface instance must be built with the same DIGITS value as this module.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_serial_adder_if.slave    bus
);

    localparam int W    = 4 * DIGITS;
    // Keep the index at least one bit wide so DIGITS=1 still elaborates.
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [IDXW-1:0]     idx;
    logic [W-1:0]        op_a;
    logic [W-1:0]        op_b;
    logic                carry;

    logic                busy_q;
    logic                done_q;
    logic [W-1:0]        sum_q;
    logic                cout_q;
    logic                err_q;

    // Operand validity is judged on the values present at the accept edge.
    logic                in_err;

    always_comb begin
        in_err = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if ((bus.a[4*d +: 4] > 4'd9) || (bus.b[4*d +: 4] > 4'd9)) begin
                in_err = 1'b1;
            end
        end
    end

    // Single digit stage working on the current index.
    logic [IDXW+1:0]     dig_pos;
    logic [3:0]          a_dig;
    logic [3:0]          b_dig;
    logic [4:0]          dig_raw;
    logic [4:0]          dig_adj;
    logic                dig_cy;
    logic [3:0]          dig_out;
    logic                last;

    always_comb begin
        dig_pos = {idx, 2'b00};
        a_dig   = op_a[dig_pos +: 4];
        b_dig   = op_b[dig_pos +: 4];
        // 5 bits hold the worst case 15 + 15 + 1 = 31 from invalid digits.
        dig_raw = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry};
        dig_adj = dig_raw + 5'd6;
        // Any overflow past 9 produces a single decimal carry, even for
        // invalid digits where dig_raw can reach 31; it never wraps to 0.
        dig_cy  = (dig_raw > 5'd9);
        dig_out = dig_cy ? dig_adj[3:0] : dig_raw[3:0];
        last    = (idx == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            carry  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_a   <= bus.a;
                        op_b   <= bus.b;
                        carry  <= bus.cin;
                        idx    <= '0;
                        err_q  <= in_err;
                        sum_q  <= '0;
                        cout_q <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end

                RUN: begin
                    sum_q[dig_pos +: 4] <= dig_out;
                    carry               <= dig_cy;
                    if (last) begin
                        cout_q <= dig_cy;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                DONE: begin
                    // Result registers hold until the next accepted start.
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.err  = err_q;

endmodule
